// File: rtl/pic_pkg.sv
// Shared definitions for the PIC command sequencer: FSM states, read
// selection, and the ICW/OCW bit positions used by the write decoder.
package pic_pkg;

    typedef enum logic [2:0] {
        ST_UNINIT    = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } pic_state_e;

    typedef enum logic {
        RSEL_IRR = 1'b0,
        RSEL_ISR = 1'b1
    } read_sel_e;

    // ICW1 fields
    localparam int ICW1_SEL = 4;
    localparam int LTIM_BIT = 3;
    localparam int SNGL_BIT = 1;
    localparam int IC4_BIT  = 0;
    // ICW4 fields
    localparam int AEOI_BIT = 1;
    // OCW3 fields
    localparam int OCW3_SEL = 3;
    localparam int RR_BIT   = 1;
    localparam int RIS_BIT  = 0;

    // An A0=0 write with bit 4 set restarts initialization from any state.
    function automatic logic is_icw1(input logic a0, input logic [7:0] d);
        return (!a0) && d[ICW1_SEL];
    endfunction

endpackage

// File: rtl/pic_inta_tracker.sv
// Follows the multi-pulse INTA acknowledge cycle: counts INTA_N falling
// edges, flags the edge on which the vector must be captured, and holds the
// bus-drive enable until INTA_N returns high.
module pic_inta_tracker #(
    parameter int INTA_PULSES = 2
) (
    input  logic       clk,
    input  logic       srst,
    input  logic       inta_n_i,
    input  logic       enable_i,
    input  logic       abort_i,
    output logic [1:0] ack_phase_o,
    output logic       vec_load_o,
    output logic       vec_drive_o
);

    localparam logic [1:0] LAST_PHASE = 2'(INTA_PULSES);

    logic       inta_n_q;
    logic [1:0] phase_q, phase_d;
    logic       drive_q, drive_d;
    logic       inta_fall;
    logic       inta_rise;

    assign inta_fall = inta_n_q & ~inta_n_i;
    assign inta_rise = ~inta_n_q & inta_n_i;

    // Next phase / drive state; an abort beats any edge seen in the same cycle.
    always_comb begin
        phase_d    = phase_q;
        drive_d    = drive_q;
        vec_load_o = 1'b0;
        if (abort_i) begin
            phase_d = 2'd0;
            drive_d = 1'b0;
        end else if (enable_i) begin
            if (inta_fall) begin
                phase_d = phase_q + 2'd1;
                if (phase_q + 2'd1 == LAST_PHASE) begin
                    vec_load_o = 1'b1;
                    drive_d    = 1'b1;
                end
            end else if (inta_rise && drive_q) begin
                phase_d = 2'd0;
                drive_d = 1'b0;
            end
        end
    end

    // Edge-detect history plus phase and drive registers; idle INTA_N is high.
    always_ff @(posedge clk) begin
        if (srst) begin
            inta_n_q <= 1'b1;
            phase_q  <= 2'd0;
            drive_q  <= 1'b0;
        end else begin
            inta_n_q <= inta_n_i;
            phase_q  <= phase_d;
            drive_q  <= drive_d;
        end
    end

    assign ack_phase_o = phase_q;
    assign vec_drive_o = drive_q;

endmodule

// File: rtl/pic_control_logic.sv
// 8259A-style command sequencer: decodes ICW1-ICW4 / OCW1-OCW3 writes,
// drives the resolver configuration, serves status reads and places the
// interrupt vector on the bus during the final INTA pulse.
module pic_control_logic
    import pic_pkg::*;
#(
    parameter int         INTA_PULSES  = 2,
    parameter logic [4:0] VEC_BASE_RST = 5'b00000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       WR,
    input  logic       RD,
    input  logic       A0,
    input  logic [7:0] D_IN,
    input  logic       INTA_N,
    input  logic [2:0] INT_VEC,
    input  logic [7:0] IRR,
    input  logic [7:0] ISR,
    input  logic [7:0] IMR,
    output logic       LTIM,
    output logic [7:0] IM,
    output logic [7:0] OPERATION,
    output logic       OP_STROBE,
    output logic       AEOI,
    output logic       SNGL,
    output logic [7:0] CAS_REG,
    output logic       INIT_DONE,
    output logic [1:0] ACK_PHASE,
    output logic [7:0] D_OUT,
    output logic       D_OE
);

    pic_state_e state_q, state_d;

    logic       ltim_q;
    logic       sngl_q;
    logic       ic4_q;
    logic       aeoi_q;
    logic [7:0] im_q;
    logic [7:0] op_q;
    logic       op_strobe_q;
    logic [7:0] cas_q;
    logic [4:0] t_q;
    read_sel_e  read_sel_q;
    logic [7:0] dout_q;
    logic       rd_oe_q;

    logic       wr_icw1;
    logic       wr_ready_a0_0;
    logic       is_ready;
    logic       vec_load;
    logic       vec_drive;
    logic [7:0] rd_data;

    assign wr_icw1       = WR && is_icw1(A0, D_IN);
    assign is_ready      = (state_q == ST_READY);
    assign wr_ready_a0_0 = WR && is_ready && !A0 && !D_IN[ICW1_SEL];
    assign rd_data       = A0 ? IMR : ((read_sel_q == RSEL_ISR) ? ISR : IRR);

    pic_inta_tracker #(
        .INTA_PULSES (INTA_PULSES)
    ) u_inta (
        .clk         (CLK),
        .srst        (RESET),
        .inta_n_i    (INTA_N),
        .enable_i    (is_ready),
        .abort_i     (wr_icw1),
        .ack_phase_o (ACK_PHASE),
        .vec_load_o  (vec_load),
        .vec_drive_o (vec_drive)
    );

    // Initialization sequence: ICW1 restarts it; A0=1 writes advance it,
    // skipping ICW3 in single mode and ICW4 when IC4 was clear.
    always_comb begin
        state_d = state_q;
        if (wr_icw1) begin
            state_d = ST_WAIT_ICW2;
        end else if (WR && A0) begin
            case (state_q)
                ST_WAIT_ICW2: begin
                    if (!sngl_q)    state_d = ST_WAIT_ICW3;
                    else if (ic4_q) state_d = ST_WAIT_ICW4;
                    else            state_d = ST_READY;
                end
                ST_WAIT_ICW3: state_d = ic4_q ? ST_WAIT_ICW4 : ST_READY;
                ST_WAIT_ICW4: state_d = ST_READY;
                default:      state_d = state_q;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET) state_q <= ST_UNINIT;
        else       state_q <= state_d;
    end

    // Configuration registers loaded by the ICW/OCW write decoder.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ltim_q     <= 1'b0;
            sngl_q     <= 1'b0;
            ic4_q      <= 1'b0;
            aeoi_q     <= 1'b0;
            im_q       <= 8'h00;
            op_q       <= 8'h00;
            cas_q      <= 8'h00;
            t_q        <= VEC_BASE_RST;
            read_sel_q <= RSEL_IRR;
        end else if (wr_icw1) begin
            ltim_q     <= D_IN[LTIM_BIT];
            sngl_q     <= D_IN[SNGL_BIT];
            ic4_q      <= D_IN[IC4_BIT];
            aeoi_q     <= 1'b0;
            im_q       <= 8'h00;
            op_q       <= 8'h00;
            read_sel_q <= RSEL_IRR;
        end else if (WR) begin
            case (state_q)
                ST_WAIT_ICW2: if (A0) t_q    <= D_IN[7:3];
                ST_WAIT_ICW3: if (A0) cas_q  <= D_IN;
                ST_WAIT_ICW4: if (A0) aeoi_q <= D_IN[AEOI_BIT];
                ST_READY: begin
                    if (A0) begin
                        im_q <= D_IN;
                    end else if (!D_IN[OCW3_SEL]) begin
                        op_q <= D_IN;
                    end else if (D_IN[RR_BIT]) begin
                        read_sel_q <= read_sel_e'(D_IN[RIS_BIT]);
                    end
                end
                default: ;
            endcase
        end
    end

    // One-cycle strobe marking a fresh OCW2 on OPERATION.
    always_ff @(posedge CLK) begin
        if (RESET) op_strobe_q <= 1'b0;
        else       op_strobe_q <= wr_ready_a0_0 && !D_IN[OCW3_SEL];
    end

    // Bus data: the INTA vector wins over status reads; reads see the
    // pre-write register values because they are captured on the same edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            dout_q  <= 8'h00;
            rd_oe_q <= 1'b0;
        end else begin
            rd_oe_q <= RD && !vec_drive && !vec_load;
            if (vec_load) begin
                dout_q <= {t_q, INT_VEC};
            end else if (RD && !vec_drive) begin
                dout_q <= rd_data;
            end
        end
    end

    assign LTIM      = ltim_q;
    assign SNGL      = sngl_q;
    assign AEOI      = aeoi_q;
    assign IM        = im_q;
    assign OPERATION = op_q;
    assign OP_STROBE = op_strobe_q;
    assign CAS_REG   = cas_q;
    assign INIT_DONE = is_ready;
    assign D_OUT     = dout_q;
    assign D_OE      = vec_drive | rd_oe_q;

endmodule

// File: tb/tb_pic_control_logic.sv
// Bench for pic_control_logic: directed scenarios followed by random
// transactions, checked against a behavioural model and a D_OUT scoreboard.
module tb_pic_control_logic;

    logic       CLK = 1'b0;
    logic       RESET, WR, RD, A0, INTA_N;
    logic [7:0] D_IN, IRR, ISR, IMR;
    logic [2:0] INT_VEC;
    logic       LTIM, OP_STROBE, AEOI, SNGL, INIT_DONE, D_OE;
    logic [7:0] IM, OPERATION, CAS_REG, D_OUT;
    logic [1:0] ACK_PHASE;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    // Behavioural model: initialization is a list of still-needed ICW words.
    bit         m_init;
    int         need[$];
    bit         m_ltim, m_sngl, m_aeoi, m_ris;
    logic [7:0] m_im, m_op, m_cas;
    logic [4:0] m_t;

    pic_control_logic #(.INTA_PULSES(2), .VEC_BASE_RST(5'b00000)) dut (
        .CLK(CLK), .RESET(RESET), .WR(WR), .RD(RD), .A0(A0), .D_IN(D_IN),
        .INTA_N(INTA_N), .INT_VEC(INT_VEC), .IRR(IRR), .ISR(ISR), .IMR(IMR),
        .LTIM(LTIM), .IM(IM), .OPERATION(OPERATION), .OP_STROBE(OP_STROBE),
        .AEOI(AEOI), .SNGL(SNGL), .CAS_REG(CAS_REG), .INIT_DONE(INIT_DONE),
        .ACK_PHASE(ACK_PHASE), .D_OUT(D_OUT), .D_OE(D_OE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: every cycle the bus is driven must match the next expected byte.
    always @(negedge CLK) begin
        if (RESET === 1'b0 && D_OE === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_d_oe", {24'h0, D_OUT}, 32'hFFFF_FFFF);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("d_out", {24'h0, D_OUT}, {24'h0, e});
                $display("bus word d_out=%02h expected=%02h", D_OUT, e);
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    function automatic bit m_ready();
        return m_init && (need.size() == 0);
    endfunction

    task automatic model_reset();
        m_init = 0; need.delete();
        m_ltim = 0; m_sngl = 0; m_aeoi = 0; m_ris = 0;
        m_im = 8'h00; m_op = 8'h00; m_cas = 8'h00; m_t = 5'b00000;
    endtask

    task automatic model_write(input logic a0, input logic [7:0] d);
        int w;
        if (!a0 && d[4]) begin
            m_init = 1; m_ltim = d[3]; m_sngl = d[1];
            m_im = 8'h00; m_op = 8'h00; m_aeoi = 0; m_ris = 0;
            need.delete();
            need.push_back(2);
            if (!d[1]) need.push_back(3);
            if (d[0])  need.push_back(4);
        end else if (m_init && need.size() > 0) begin
            if (a0) begin
                w = need.pop_front();
                if (w == 2)      m_t = d[7:3];
                else if (w == 3) m_cas = d;
                else             m_aeoi = d[1];
            end
        end else if (m_ready()) begin
            if (a0)        m_im = d;
            else if (!d[3]) m_op = d;
            else if (d[1]) m_ris = d[0];
        end
    endtask

    task automatic check_cfg();
        check("ltim", LTIM, m_ltim);
        check("sngl", SNGL, m_sngl);
        check("aeoi", AEOI, m_aeoi);
        check("im", IM, m_im);
        check("operation", OPERATION, m_op);
        check("cas_reg", CAS_REG, m_cas);
        check("init_done", INIT_DONE, m_ready());
        check("ack_phase_idle", ACK_PHASE, 0);
        check("d_oe_idle", D_OE, 0);
    endtask

    task automatic do_write(input logic a0, input logic [7:0] d);
        logic exp_strobe;
        exp_strobe = m_ready() && !a0 && (d[4:3] == 2'b00);
        WR = 1; A0 = a0; D_IN = d;
        step();
        WR = 0;
        model_write(a0, d);
        $display("write a0=%0b d=%02h ready=%0b", a0, d, m_ready());
        check("op_strobe", OP_STROBE, exp_strobe);
        check_cfg();
        step();
        check("op_strobe_clear", OP_STROBE, 0);
    endtask

    task automatic do_read(input logic a0, input logic [7:0] irr, input logic [7:0] isr, input logic [7:0] imr);
        IRR = irr; ISR = isr; IMR = imr;
        exp_q.push_back(a0 ? imr : (m_ris ? isr : irr));
        RD = 1; A0 = a0;
        step();
        check("rd_d_oe", D_OE, 1);
        RD = 0; IRR = ~irr; ISR = ~isr; IMR = ~imr;
        step();
        $display("read a0=%0b", a0);
        check("rd_drained", exp_q.size(), 0);
        check("rd_d_oe_off", D_OE, 0);
    endtask

    // Simultaneous write and read: the read returns the pre-write selection.
    task automatic do_write_read(input logic [7:0] d);
        IRR = 8'h33; ISR = 8'hCC;
        exp_q.push_back(m_ris ? ISR : IRR);
        WR = 1; RD = 1; A0 = 0; D_IN = d;
        step();
        WR = 0; RD = 0;
        model_write(1'b0, d);
        step();
        $display("write+read d=%02h", d);
        check("wr_rd_drained", exp_q.size(), 0);
        check_cfg();
    endtask

    task automatic do_inta(input int lo, input logic [2:0] vec);
        bit rdy;
        rdy = m_ready();
        INTA_N = 0;
        step();
        check("ack_p1", ACK_PHASE, rdy ? 1 : 0);
        repeat (lo - 1) step();
        INTA_N = 1;
        step();
        check("ack_p1_rise", ACK_PHASE, rdy ? 1 : 0);
        check("d_oe_p1", D_OE, 0);
        INT_VEC = vec;
        if (rdy) repeat (lo) exp_q.push_back({m_t, vec});
        INTA_N = 0;
        step();
        check("ack_p2", ACK_PHASE, rdy ? 2 : 0);
        check("d_oe_p2", D_OE, rdy);
        INT_VEC = ~vec;
        repeat (lo - 1) step();
        INTA_N = 1;
        step();
        check("ack_done", ACK_PHASE, 0);
        check("d_oe_done", D_OE, 0);
        step();
        $display("inta lo=%0d vec=%0d ready=%0b", lo, vec, rdy);
        check("inta_drained", exp_q.size(), 0);
    endtask

    initial begin
        RESET = 1; WR = 0; RD = 0; A0 = 0; D_IN = 8'h00; INTA_N = 1;
        INT_VEC = 3'd0; IRR = 8'h00; ISR = 8'h00; IMR = 8'h00;
        model_reset();
        repeat (3) step();
        RESET = 0;
        step();
        check_cfg();
        check("d_out_reset", D_OUT, 8'h00);
        check("op_strobe_reset", OP_STROBE, 0);

        // Single mode with ICW4: ICW3 skipped, AEOI set.
        do_write(1'b0, 8'h13);
        do_write(1'b1, 8'h48);
        check("not_ready_after_icw2", INIT_DONE, 0);
        do_write(1'b1, 8'h03);
        check("aeoi_set", AEOI, 1);
        check("ready_after_icw4", INIT_DONE, 1);
        do_inta(2, 3'd5);

        // Cascade, level-triggered, no ICW4.
        do_write(1'b0, 8'h18);
        do_write(1'b1, 8'h20);
        do_write(1'b1, 8'h04);
        check("cas_04", CAS_REG, 8'h04);
        check("ltim_1", LTIM, 1);
        check("ready_no_icw4", INIT_DONE, 1);

        // OCW1 / OCW2.
        do_write(1'b1, 8'hF0);
        do_write(1'b0, 8'h20);

        // OCW3 read selection and IMR read.
        do_write(1'b0, 8'h0B);
        do_read(1'b0, 8'h55, 8'h08, 8'hA5);
        do_write(1'b0, 8'h0A);
        do_read(1'b0, 8'h55, 8'h08, 8'hA5);
        do_read(1'b1, 8'h55, 8'h08, 8'hA5);
        do_write_read(8'h0B);
        do_read(1'b0, 8'h11, 8'h22, 8'h44);

        // ICW1 after the first INTA pulse aborts the cycle.
        INTA_N = 0; step();
        check("abort_a_ack1", ACK_PHASE, 1);
        INTA_N = 1; step();
        do_write(1'b0, 8'h13);
        do_inta(2, 3'd2);
        do_write(1'b1, 8'h48);
        do_write(1'b1, 8'h00);

        // ICW1 while the vector is on the bus.
        INTA_N = 0; step();
        INTA_N = 1; step();
        INT_VEC = 3'd3;
        exp_q.push_back({m_t, 3'd3});
        INTA_N = 0; step();
        check("abort_b_d_oe", D_OE, 1);
        do_write(1'b0, 8'h17);
        INTA_N = 1; step();
        check("abort_b_drained", exp_q.size(), 0);
        check("abort_b_ack", ACK_PHASE, 0);

        // Reset in the middle of an acknowledge cycle.
        do_write(1'b1, 8'h90);
        do_write(1'b1, 8'h02);
        INTA_N = 0; step();
        check("rst_mid_ack1", ACK_PHASE, 1);
        RESET = 1; step();
        RESET = 0; model_reset();
        check("rst_mid_ack0", ACK_PHASE, 0);
        check("rst_mid_d_oe", D_OE, 0);
        INTA_N = 1; step();
        check_cfg();
        do_write(1'b1, 8'h77);
        do_write(1'b0, 8'h00);

        // Random traffic.
        do_write(1'b0, 8'h13);
        do_write(1'b1, 8'hA8);
        do_write(1'b1, 8'h01);
        for (int i = 0; i < 250; i++) begin
            int r;
            logic [7:0] d;
            r = $urandom_range(0, 9);
            d = 8'($urandom);
            case (r)
                0: begin d[4] = 1'b1; do_write(1'b0, d); end
                1, 2: do_write(1'b1, d);
                3, 4: begin d[4] = 1'b0; do_write(1'b0, d); end
                5, 6: do_read(1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
                7, 8: do_inta($urandom_range(1, 3), 3'($urandom));
                default: begin repeat ($urandom_range(1, 3)) step(); check_cfg(); end
            endcase
        end

        repeat (3) step();
        check("final_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
